// File: rtl/yin_difference.sv
// yin_difference: freezes the sample ring buffer and, for each lag tau in 1..TAU_MAX,
// accumulates d(tau) = sum_j (x[j] - x[j+tau])^2 through the buffer's read port.
module yin_difference #(
    parameter int  ENTRIES    = 2048,
    parameter int  DATA_WIDTH = 16,
    parameter int  WINDOW     = 1024,
    parameter int  TAU_MAX    = 1024,
    localparam int ADDRSIZE   = $clog2(ENTRIES),
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(WINDOW),
    localparam int TAU_WIDTH  = $clog2(TAU_MAX+1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic                  shift_block_out,
    output logic [ADDRSIZE-1:0]   rb_read_addr_out,
    output logic                  rb_read_trigger_out,
    input  logic                  rb_read_ready_in,
    input  logic [DATA_WIDTH-1:0] rb_data_in,
    input  logic                  rb_data_valid_in,
    output logic [ACC_WIDTH-1:0]  diff_out,
    output logic [TAU_WIDTH-1:0]  tau_out,
    output logic                  diff_valid_out,
    output logic                  done_out
);

    localparam int JW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    if (WINDOW + TAU_MAX > ENTRIES) begin : g_cfg_check
        $error("yin_difference: WINDOW + TAU_MAX must not exceed ENTRIES");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        WAIT_A,
        ISSUE_B,
        WAIT_B,
        ACCUM
    } state_t;

    state_t                  state_q,   state_d;
    logic [JW-1:0]           j_q,       j_d;
    logic [TAU_WIDTH-1:0]    tau_q,     tau_d;
    logic [DATA_WIDTH-1:0]   a_q,       a_d;
    logic [2*DATA_WIDTH-1:0] sq_q,      sq_d;
    logic [ACC_WIDTH-1:0]    acc_q,     acc_d;
    logic [ACC_WIDTH-1:0]    diff_q,    diff_d;
    logic [TAU_WIDTH-1:0]    tau_out_q, tau_out_d;
    logic                    valid_q,   valid_d;
    logic                    done_q,    done_d;

    logic [DATA_WIDTH:0]     delta;
    logic [DATA_WIDTH:0]     mag;
    logic [2*DATA_WIDTH-1:0] mag_w;
    logic [2*DATA_WIDTH-1:0] sq_next;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic                    last_term;
    logic                    last_tau;

    // |a - b| fits DATA_WIDTH bits, so squaring the magnitude is exact in 2*DATA_WIDTH.
    assign delta   = {a_q[DATA_WIDTH-1], a_q} - {rb_data_in[DATA_WIDTH-1], rb_data_in};
    assign mag     = delta[DATA_WIDTH] ? (-delta) : delta;
    assign mag_w   = (2*DATA_WIDTH)'(mag[DATA_WIDTH-1:0]);
    assign sq_next = mag_w * mag_w;

    assign acc_sum   = acc_q + ACC_WIDTH'(sq_q);
    assign last_term = (j_q == JW'(WINDOW-1));
    assign last_tau  = (tau_q == TAU_WIDTH'(TAU_MAX));

    always_comb begin
        state_d             = state_q;
        j_d                 = j_q;
        tau_d               = tau_q;
        a_d                 = a_q;
        sq_d                = sq_q;
        acc_d               = acc_q;
        diff_d              = diff_q;
        tau_out_d           = tau_out_q;
        valid_d             = 1'b0;
        done_d              = 1'b0;
        rb_read_addr_out    = '0;
        rb_read_trigger_out = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q still counts as busy, so a start in that cycle is ignored
                if (start_in && !done_q) begin
                    state_d = ISSUE_A;
                    tau_d   = TAU_WIDTH'(1);
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            ISSUE_A: begin
                rb_read_addr_out = ADDRSIZE'(j_q);
                if (rb_read_ready_in) begin
                    rb_read_trigger_out = 1'b1;
                    state_d             = WAIT_A;
                end
            end
            WAIT_A: begin
                if (rb_data_valid_in) begin
                    a_d     = rb_data_in;
                    state_d = ISSUE_B;
                end
            end
            ISSUE_B: begin
                rb_read_addr_out = ADDRSIZE'(j_q) + ADDRSIZE'(tau_q);
                if (rb_read_ready_in) begin
                    rb_read_trigger_out = 1'b1;
                    state_d             = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rb_data_valid_in) begin
                    sq_d    = sq_next;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!last_term) begin
                    acc_d   = acc_sum;
                    j_d     = j_q + JW'(1);
                    state_d = ISSUE_A;
                end else begin
                    diff_d    = acc_sum;
                    tau_out_d = tau_q;
                    valid_d   = 1'b1;
                    acc_d     = '0;
                    j_d       = '0;
                    if (last_tau) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tau_d   = tau_q + TAU_WIDTH'(1);
                        state_d = ISSUE_A;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            j_q       <= '0;
            tau_q     <= '0;
            a_q       <= '0;
            sq_q      <= '0;
            acc_q     <= '0;
            diff_q    <= '0;
            tau_out_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            tau_q     <= tau_d;
            a_q       <= a_d;
            sq_q      <= sq_d;
            acc_q     <= acc_d;
            diff_q    <= diff_d;
            tau_out_q <= tau_out_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign busy_out        = (state_q != IDLE) || done_q;
    assign shift_block_out = busy_out;
    assign diff_out        = diff_q;
    assign tau_out         = tau_out_q;
    assign diff_valid_out  = valid_q;
    assign done_out        = done_q;

endmodule

// File: doc/yin_difference.md
# yin_difference

Downstream consumer of the audio sample ring buffer in the autotune pitch path. On `start_in` it freezes the buffer and, for each lag tau in 1..TAU_MAX, reads WINDOW sample pairs through the buffer's read port. For each lag it emits the squared-difference sum d(tau) = sum over j in 0..WINDOW-1 of (x[j] - x[j+tau])^2, one result per tau, for the YIN normalisation / minimum-search stage that follows.

## Interface
- ENTRIES, 2048: ring buffer depth; ADDRSIZE = $clog2(ENTRIES).
- DATA_WIDTH, 16: signed sample width.
- WINDOW, 1024: terms per lag.
- TAU_MAX, 1024: largest lag. Elaboration error unless WINDOW + TAU_MAX <= ENTRIES.
- ACC_WIDTH, 2*DATA_WIDTH + $clog2(WINDOW): accumulator / result width (derived, not overridden).
- TAU_WIDTH, $clog2(TAU_MAX+1): lag index width (derived).

Ports:
- clk_in  in  1  single clock
- rst_in  in  1  reset, synchronous, active-low
- start_in  in  1  begin one full d(tau) sweep
- busy_out  out  1  sweep in progress
- shift_block_out  out  1  equals busy_out; upstream gates the buffer's shift_trigger with it
- rb_read_addr_out  out  ADDRSIZE  buffer logical read address (0 = oldest sample)
- rb_read_trigger_out  out  1  buffer read strobe
- rb_read_ready_in  in  1  buffer read_ready_out
- rb_data_in  in  DATA_WIDTH  buffer data_out (signed)
- rb_data_valid_in  in  1  buffer data_valid_out
- diff_out  out  ACC_WIDTH  d(tau), unsigned
- tau_out  out  TAU_WIDTH  lag belonging to diff_out
- diff_valid_out  out  1  one-cycle pulse per result
- done_out  out  1  one-cycle pulse with the final (tau = TAU_MAX) result

## Operation
- Reset (rst_in = 0 at a clock edge): state IDLE. All outputs are 0, and so are the tau, j and accumulator registers. A sweep in progress is abandoned with no further diff_valid_out or done_out.
- States:
  - IDLE: start_in = 1 -> ISSUE_A with tau = 1, j = 0, acc = 0.
  - ISSUE_A: drive addr = j. When rb_read_ready_in = 1, assert trigger for one cycle -> WAIT_A.
  - WAIT_A: on rb_data_valid_in, capture a = rb_data_in -> ISSUE_B.
  - ISSUE_B: drive addr = j + tau. When ready, trigger -> WAIT_B.
  - WAIT_B: on valid, register sq = (a - b)^2 -> ACCUM.
  - ACCUM, when j < WINDOW-1: acc += sq, j++ -> ISSUE_A.
  - ACCUM, when j = WINDOW-1: diff_out <= acc + sq, tau_out <= tau, diff_valid_out <= 1, acc <= 0, j <= 0. If tau = TAU_MAX, done_out <= 1 -> IDLE; else tau++ -> ISSUE_A.
- Triggers are asserted only when rb_read_ready_in = 1, with at most one read outstanding. WAIT states tolerate any latency ≥ 1.
- Arithmetic:
  - a - b is computed sign-extended to DATA_WIDTH+1 bits.
  - The square is unsigned 2*DATA_WIDTH bits; it is exact because the maximum |a-b| is 2^DATA_WIDTH - 1.
  - The accumulator cannot overflow at ACC_WIDTH, so there is no saturation.
- busy_out / shift_block_out is high from the cycle after start is accepted through the cycle in which done_out is high.
- start_in is ignored while busy_out = 1.
- diff_out and tau_out hold their last values until the next result.

## Timing
- Reference buffer behaviour: read latency 2 (valid two cycles after trigger), and ready low only in the cycle after a trigger.
- With that buffer, one term takes 7 cycles: ISSUE_A, WAIT_A x2, ISSUE_B, WAIT_B x2, ACCUM.
- One lag takes 7*WINDOW cycles. There are no bubbles between lags.
- Cycle numbering: start_in sampled in IDLE at cycle 0; ISSUE_A is cycle 1.
  - First diff_valid_out is at cycle 7*WINDOW + 1.
  - Result k (1-based) is at cycle 7*WINDOW*k + 1.
  - done_out coincides with result TAU_MAX.
- Back-to-back sweep: start_in high in the cycle after done_out is accepted (IDLE).

## Test plan
All scenarios use a ring buffer model with the latency above and ENTRIES=16, DATA_WIDTH=8, WINDOW=4, TAU_MAX=4.
- Constant buffer, all samples 5; start pulse -> four results, tau 1..4, all diff_out = 0; diff_valid_out at cycles 29, 57, 85, 113; done_out at 113.
- Ramp, x[i] = i -> diff_out = 4, 16, 36, 64 for tau 1..4.
- Alternating extremes, x[even] = -128, x[odd] = 127 -> tau 1, 3 give 260100; tau 2, 4 give 0; no overflow.
- start_in re-pulsed at cycles 10 and 60 -> ignored, exactly four results. shift_block_out is high for cycles 1..113 and low at 114. No rb_read_trigger_out is ever asserted while rb_read_ready_in = 0.
- rst_in low at cycle 40 for one cycle -> next cycle all outputs are 0 and the state is IDLE. No further diff_valid_out. A new start yields the correct ramp results.
- Buffer model with latency stretched to 5 -> same values as the ramp test; per-term period becomes 13 cycles.
